// File: rtl/opb_register_simulink2ppc_latched.sv
// opb_register_simulink2ppc_latched: fabric word latched into a PPC-readable OPB status register
module opb_register_simulink2ppc_latched #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid
);
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    state_t state, state_nx;
    logic [C_OPB_AWIDTH-1:0] rel;
    logic [31:0] wd, rd_word, shadow;
    logic [15:0] count;
    logic [7:0] off;
    logic hit, ack, new_flag, ovf_flag, freeze;
    logic acc, rd_data, wr_stat, wr_ctrl, clr_ovf, clr_cnt, set_ovf, unused;
    assign rel = OPB_ABus - C_BASEADDR[C_OPB_AWIDTH-1:0];
    assign hit = OPB_select && rel <= (C_HIGHADDR[C_OPB_AWIDTH-1:0] - C_BASEADDR[C_OPB_AWIDTH-1:0]);
    assign off = rel[7:0];
    assign wd = OPB_DBus;
    assign ack = state == ACK;
    assign acc = user_valid && !freeze;
    assign rd_data = ack && OPB_RNW && off == 8'h00;
    assign wr_stat = ack && !OPB_RNW && off == 8'h04;
    assign wr_ctrl = ack && !OPB_RNW && off == 8'h08;
    assign clr_ovf = wr_stat && wd[31];
    assign clr_cnt = wr_stat && wd[0];
    // a DATA read consuming the old sample in the same cycle as a capture is not an overflow
    assign set_ovf = user_valid && (freeze || (new_flag && !rd_data));
    assign unused = ^{OPB_BE, OPB_seqAddr, wd[30:1]} ^ (C_FAMILY == "");
    always_ff @(posedge OPB_Clk) begin
        state <= !OPB_Rst_n ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (hit ? ACK : IDLE) : state == ACK ? HOLD : (OPB_select ? HOLD : IDLE);
        rd_word = off == 8'h00 ? shadow :
                  off == 8'h04 ? {ovf_flag, new_flag, 14'b0, count} :
                  off == 8'h08 ? {31'b0, freeze} : 32'b0;
    end
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            shadow <= '0;
            count <= '0;
            new_flag <= 1'b0;
            ovf_flag <= 1'b0;
            freeze <= 1'b0;
        end else begin
            shadow <= acc ? user_data_in : shadow;
            count <= clr_cnt ? 16'h0 : acc ? count + 16'h1 : count;
            new_flag <= acc ? 1'b1 : rd_data ? 1'b0 : new_flag;
            ovf_flag <= clr_ovf ? 1'b0 : set_ovf ? 1'b1 : ovf_flag;
            freeze <= wr_ctrl ? wd[0] : freeze;
        end
    end
    assign Sl_DBus = ack && OPB_RNW ? rd_word : '0;
    assign Sl_xferAck = ack;
    assign Sl_errAck = 1'b0;
    assign Sl_retry = 1'b0;
    assign Sl_toutSup = 1'b0;
endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
// tb_opb_register_simulink2ppc_latched: directed OPB transfers checked by a queue-based scoreboard
module tb_opb_register_simulink2ppc_latched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [0:31] abus = '0;
    logic [0:3] be = 4'hF;
    logic [0:31] dbus = '0;
    logic rnw = 1'b1;
    logic sel = 1'b0;
    logic seq = 1'b0;
    logic [0:31] sl_dbus;
    logic ack, err_ack, retry, tout_sup;
    logic [31:0] ud = '0;
    logic uv = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    opb_register_simulink2ppc_latched dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err_ack),
        .Sl_retry(retry), .Sl_toutSup(tout_sup),
        .user_data_in(ud), .user_valid(uv)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual_dbus=%h required=no_ack", sl_dbus);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_dbus", sl_dbus, mon_e);
                chk("side_outs", {29'b0, err_ack, retry, tout_sup}, 32'h0);
            end
        end
    end

    task automatic xfer(input logic r, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] e, input int hold, input logic sv, input logic [31:0] sd);
        int n;
        @(posedge clk); #1;
        abus = a; rnw = r; dbus = w; sel = 1'b1;
        exp_q.push_back(r ? e : 32'h0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        chk("ack_latency", n, 1);
        if (!ack) void'(exp_q.pop_back());
        if (sv) begin
            uv = 1'b1;
            ud = sd;
        end
        @(posedge clk); #1;
        uv = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        sel = 1'b0; rnw = 1'b1; dbus = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        xfer(1'b1, a, 32'h0, e, 0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] w);
        xfer(1'b0, a, w, 32'h0, 0, 1'b0, 32'h0);
    endtask

    task automatic strobe(input logic [31:0] d, input int n);
        @(posedge clk); #1;
        uv = 1'b1;
        for (int i = 0; i < n; i++) begin
            ud = d + i;
            @(posedge clk); #1;
        end
        uv = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'b0, ack}, 32'h0);
        chk("reset_dbus", sl_dbus, 32'h0);
        rst_n = 1'b1;
        rd(32'h00, 32'h0000_0000);
        rd(32'h04, 32'h0000_0000);
        strobe(32'hDEAD_BEEF, 1);
        rd(32'h04, 32'h4000_0001);
        rd(32'h00, 32'hDEAD_BEEF);
        rd(32'h04, 32'h0000_0001);
        strobe(32'h1111_1111, 1);
        strobe(32'h2222_2222, 1);
        rd(32'h04, 32'hC000_0003);
        wr(32'h04, 32'h8000_0001);
        rd(32'h04, 32'h4000_0000);
        wr(32'h08, 32'h0000_0001);
        rd(32'h08, 32'h0000_0001);
        strobe(32'h1234_5678, 1);
        rd(32'h00, 32'h2222_2222);
        rd(32'h04, 32'h8000_0000);
        wr(32'h08, 32'h0000_0000);
        strobe(32'h1234_5678, 1);
        rd(32'h00, 32'h1234_5678);
        rd(32'h04, 32'h8000_0001);
        wr(32'h04, 32'h8000_0000);
        rd(32'h04, 32'h0000_0001);
        wr(32'h00, 32'hFFFF_FFFF);
        rd(32'h00, 32'h1234_5678);
        rd(32'h10, 32'h0000_0000);
        wr(32'h0C, 32'hFFFF_FFFF);
        rd(32'h08, 32'h0000_0000);
        strobe(32'hAAAA_0001, 1);
        rd(32'h00, 32'hAAAA_0001);
        xfer(1'b1, 32'h00, 32'h0, 32'hAAAA_0001, 0, 1'b1, 32'hBBBB_0002);
        rd(32'h04, 32'h4000_0003);
        rd(32'h00, 32'hBBBB_0002);
        xfer(1'b0, 32'h04, 32'h0000_0001, 32'h0, 0, 1'b1, 32'hCCCC_0003);
        rd(32'h04, 32'h4000_0000);
        rd(32'h00, 32'hCCCC_0003);
        strobe(32'hDDDD_0004, 1);
        xfer(1'b0, 32'h04, 32'h8000_0000, 32'h0, 0, 1'b1, 32'hEEEE_0005);
        rd(32'h04, 32'h4000_0002);
        wr(32'h04, 32'h8000_0001);
        strobe(32'h0, 65535);
        rd(32'h04, 32'hC000_FFFF);
        strobe(32'h5A5A_0000, 1);
        rd(32'h04, 32'hC000_0000);
        rd(32'h00, 32'h5A5A_0000);
        @(posedge clk); #1;
        abus = 32'h100; rnw = 1'b1; sel = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("miss_ack", {31'b0, ack}, 32'h0);
            chk("miss_dbus", sl_dbus, 32'h0);
        end
        sel = 1'b0;
        xfer(1'b1, 32'h04, 32'h0, 32'h8000_0000, 3, 1'b0, 32'h0);
        @(posedge clk); #1;
        abus = 32'h08; rnw = 1'b1; sel = 1'b1;
        exp_q.push_back(32'h0);
        @(posedge clk); #1;
        chk("rst_hold_first_ack", {31'b0, ack}, 32'h1);
        if (!ack) void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0;
        chk("rst_hold_ack_in_reset", {31'b0, ack}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_hold_no_ack", {31'b0, ack}, 32'h0);
        end
        rd(32'h04, 32'h0000_0000);
        rd(32'h00, 32'h0000_0000);
        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
